// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit holding the architectural HI/LO pair.
// Mul is radix-2 shift-add, div is restoring shift-subtract, one bit per cycle.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush_ex,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   raw_a;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               div_zero;

  logic op_ok, accept, is_md, is_sgn, is_dv;
  logic a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign busy   = (state != IDLE);
  assign op_ok  = (op != 3'b000) && (op != 3'b111);
  assign accept = start & ~flush_ex & ~busy & op_ok;
  assign is_md  = (op == OP_MULT) || (op == OP_MULTU) ||
                  (op == OP_DIV)  || (op == OP_DIVU);
  assign is_sgn = (op == OP_MULT) || (op == OP_DIV);
  assign is_dv  = (op == OP_DIV)  || (op == OP_DIVU);
  assign a_neg  = is_sgn & op_a[WIDTH-1];
  assign b_neg  = is_sgn & op_b[WIDTH-1];
  assign abs_a  = a_neg ? -op_a : op_a;
  assign abs_b  = b_neg ? -op_b : op_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                    (acc[0] ? {1'b0, mag_a} : '0);
  // Partial remainder with the next dividend bit shifted in.
  assign div_rem  = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_rem - {1'b0, mag_b};
  assign prod     = neg_lo ? -acc : acc;
  assign quo      = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem      = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      raw_a    <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (1'b1)
              is_md: begin
                mag_a    <= abs_a;
                mag_b    <= abs_b;
                raw_a    <= op_a;
                is_div   <= is_dv;
                neg_lo   <= a_neg ^ b_neg;
                neg_hi   <= a_neg;
                div_zero <= (op_b == '0);
                acc      <= {{WIDTH{1'b0}}, is_dv ? abs_a : abs_b};
                cnt      <= '0;
                state    <= CALC;
              end
              (op == OP_MTHI): hi <= op_a;
              (op == OP_MTLO): lo <= op_a;
            endcase
          end
        end
        CALC: begin
          if (is_div) begin
            if (div_diff[WIDTH])
              acc <= {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
              acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST)
            state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end else if (div_zero) begin
            hi <= raw_a;
            lo <= '1;
          end else begin
            hi <= rem;
            lo <= quo;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected HI/LO queued at issue,
// popped and compared on the done pulse.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush_ex;
  logic [2:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .flush_ex (flush_ex),
    .op       (op),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  logic [63:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [63:0] model(input logic [2:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb64, sp;
    logic signed [31:0] q, r;
    case (o)
      3'b001: begin
        sa = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        sp = sa * sb64;
        return sp;
      end
      3'b010: return {32'b0, a} * {32'b0, b};
      3'b011: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      3'b100: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input int inj);
    int cnt;
    logic [63:0] e;
    @(negedge clk);
    op = o; op_a = a; op_b = b; start = 1'b1; flush_ex = 1'b0;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0; op = 3'b000;
    chk("busy_set", {63'b0, busy}, 64'd1);
    cnt = 0;
    while (busy && cnt < 40) begin
      start = 1'b0; flush_ex = 1'b0;
      if (cnt == inj) begin
        start = 1'b1; op = 3'b101; op_a = 32'hDEAD_BEEF;
      end else if (cnt == inj + 1) begin
        flush_ex = 1'b1;
      end
      cnt++;
      @(negedge clk);
    end
    start = 1'b0; flush_ex = 1'b0; op = 3'b000;
    chk("busy_cycles", 64'(cnt), 64'd33);
    chk("done_pulse", {63'b0, done}, 64'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk("hi", {32'b0, hi}, {32'b0, e[63:32]});
      chk("lo", {32'b0, lo}, {32'b0, e[31:0]});
    end
    @(negedge clk);
    chk("done_clr", {63'b0, done}, 64'd0);
  endtask

  task automatic move(input logic [2:0] o, input logic [31:0] a,
                      input logic fl);
    @(negedge clk);
    op = o; op_a = a; start = 1'b1; flush_ex = fl;
    @(negedge clk);
    start = 1'b0; flush_ex = 1'b0; op = 3'b000;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; flush_ex = 1'b0;
    op = 3'b000; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    rst_n = 1'b1;

    run_op(3'b001, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, -1);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFE_0000_0001, -1);
    run_op(3'b011, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, -1);
    run_op(3'b100, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF, -1);
    run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF,
           64'h0000_0000_8000_0000, -1);

    move(3'b110, 32'hAAAA_5555, 1'b0);
    chk("mtlo_lo", {32'b0, lo}, 64'h0000_0000_AAAA_5555);
    move(3'b101, 32'h1234_5678, 1'b0);
    chk("mthi_hi", {32'b0, hi}, 64'h0000_0000_1234_5678);
    chk("mthi_lo", {32'b0, lo}, 64'h0000_0000_AAAA_5555);
    chk("mthi_busy", {63'b0, busy}, 64'd0);
    chk("mthi_done", {63'b0, done}, 64'd0);

    move(3'b101, 32'h0BAD_F00D, 1'b1);
    chk("flush_hi", {32'b0, hi}, 64'h0000_0000_1234_5678);
    move(3'b001, 32'd9, 1'b1);
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_lo", {32'b0, lo}, 64'h0000_0000_AAAA_5555);

    // Start and flush injected mid-flight must not disturb the result.
    run_op(3'b010, 32'h0001_0000, 32'h0003_0000,
           64'h0000_0003_0000_0000, 12);

    @(negedge clk);
    op = 3'b001; op_a = 32'd7; op_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'b000;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", {32'b0, hi}, 64'd0);
    chk("arst_lo", {32'b0, lo}, 64'd0);
    chk("arst_busy", {63'b0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b001, 32'd2, 32'd3, 64'd6, -1);

    for (int i = 0; i < 8; i++) begin
      ro = 3'(1 + $urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : $urandom;
      if (i == 2) rb = rb >> 20;
      run_op(ro, ra, rb, model(ro, ra, rb), -1);
    end

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
